id_stage: RTL and testbench

- Instruction-decode stage that drives the EX stage inputs Ins, Rdata1, Rdata2, Ed32 and nextPC.
- Takes a fetched instruction plus nextPC and reads rs/rt from a 32x32 register file. It also extends the 16-bit immediate.
- Results are registered in an ID/EX pipeline register with a valid/ready handshake.
- The register file also has a write port, which the write-back stage drives.

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/mips_regfile.sv | 34 +++
 rtl/id_stage.sv | 99 +++++++++
 tb/tb_id_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the ID/EX bundle.
// Field positions and immediate extension rules live here.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] ed32;
    logic [31:0] npc;
  } id_ex_t;

  // Logical immediates zero-extend, LUI shifts up, the rest sign-extend.
  function automatic logic [31:0] ext_imm(
    input logic [5:0]  op,
    input logic [15:0] imm
  );
    logic [31:0] r;
    unique case (1'b1)
      (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI):
        r = {16'h0, imm};
      (op == OP_LUI):
        r = {imm, 16'h0};
      default:
        r = {{16{imm[15]}}, imm};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// GPR file: two combinational read ports, one write port.
// Register 0 is hardwired to zero; reset clears all registers.
import mips_pkg::*;

module mips_regfile #(
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [31:0]   rd1,
  output logic [31:0]   rd2,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);

  logic [31:0] gpr [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        gpr[i] <= '0;
    end else if (we && (waddr != '0)) begin
      gpr[waddr] <= wdata;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : gpr[ra1];
  assign rd2 = (ra2 == '0) ? '0 : gpr[ra2];

endmodule

// File: rtl/id_stage.sv
// Decode stage: GPR read, immediate extension, ID/EX register.
// Define WB_BYPASS_EN to forward same-cycle write-back data.
import mips_pkg::*;

module id_stage #(
  parameter int          NREG     = 32,
  parameter logic [31:0] RESET_PC = 32'h00000000,
  localparam int AW = $clog2(NREG)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   Ins,
  input  logic [31:0]   nextPC,
  input  logic          InValid,
  output logic          InReady,
  input  logic          WE,
  input  logic [AW-1:0] Waddr,
  input  logic [31:0]   Wdata,
  output logic [31:0]   InsOut,
  output logic [31:0]   Rdata1,
  output logic [31:0]   Rdata2,
  output logic [31:0]   Ed32,
  output logic [31:0]   nextPCOut,
  output logic          OutValid,
  input  logic          OutReady
);

  logic [5:0]    op;
  logic [15:0]   imm;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [31:0]   gpr1;
  logic [31:0]   gpr2;
  logic [31:0]   byp1;
  logic [31:0]   byp2;
  logic          valid;
  logic          accept;
  id_ex_t        d;
  id_ex_t        q;

  assign op  = Ins[OP_MSB:OP_LSB];
  assign imm = Ins[IMM_MSB:IMM_LSB];
  assign rs  = AW'(Ins[RS_MSB:RS_LSB]);
  assign rt  = AW'(Ins[RT_MSB:RT_LSB]);

  mips_regfile #(.NREG(NREG)) u_rf (
    .clk   (CLK),
    .rst_n (RST),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (gpr1),
    .rd2   (gpr2),
    .we    (WE),
    .waddr (Waddr),
    .wdata (Wdata)
  );

`ifdef WB_BYPASS_EN
  assign byp1 = (WE && (Waddr == rs) && (Waddr != '0)) ? Wdata : gpr1;
  assign byp2 = (WE && (Waddr == rt) && (Waddr != '0)) ? Wdata : gpr2;
`else
  assign byp1 = gpr1;
  assign byp2 = gpr2;
`endif

  assign InReady = !valid || OutReady;
  assign accept  = InValid && InReady;

  always_comb begin
    d        = '0;
    d.ins    = Ins;
    d.rdata1 = byp1;
    d.rdata2 = byp2;
    d.ed32   = ext_imm(op, imm);
    d.npc    = nextPC;
  end

  // Data only loads on accept, so stalls and drains keep outputs stable.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid <= 1'b0;
      q     <= '{ins: '0, rdata1: '0, rdata2: '0,
                 ed32: '0, npc: RESET_PC};
    end else if (accept) begin
      valid <= 1'b1;
      q     <= d;
    end else if (OutReady) begin
      valid <= 1'b0;
    end
  end

  assign OutValid  = valid;
  assign InsOut    = q.ins;
  assign Rdata1    = q.rdata1;
  assign Rdata2    = q.rdata2;
  assign Ed32      = q.ed32;
  assign nextPCOut = q.npc;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed steps plus random traffic
// against a transaction-level model of the decode stage.
module tb_id_stage;

  localparam logic [31:0] RPC = 32'h00000000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Ins;
  logic [31:0] nextPC;
  logic        InValid;
  logic        InReady;
  logic        WE;
  logic [4:0]  Waddr;
  logic [31:0] Wdata;
  logic [31:0] InsOut;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic [31:0] Ed32;
  logic [31:0] nextPCOut;
  logic        OutValid;
  logic        OutReady;

  always #5 CLK = ~CLK;

  id_stage #(.NREG(32), .RESET_PC(RPC)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Ins       (Ins),
    .nextPC    (nextPC),
    .InValid   (InValid),
    .InReady   (InReady),
    .WE        (WE),
    .Waddr     (Waddr),
    .Wdata     (Wdata),
    .InsOut    (InsOut),
    .Rdata1    (Rdata1),
    .Rdata2    (Rdata2),
    .Ed32      (Ed32),
    .nextPCOut (nextPCOut),
    .OutValid  (OutValid),
    .OutReady  (OutReady)
  );

  int checks = 0;
  int errors = 0;
  bit bypass;

  logic [31:0] gm [32];
  bit          mv;
  logic [31:0] m_ins, m_r1, m_r2, m_ed, m_pc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [31:0] i);
    int op;
    int imm;
    op  = int'(i >> 26);
    imm = int'(i & 32'hFFFF);
    if (op >= 12 && op <= 14) return 32'(imm);
    if (op == 15) return 32'(imm * 65536);
    return 32'(imm >= 32768 ? imm - 65536 : imm);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) gm[i] = '0;
    mv = 0;
    m_ins = '0; m_r1 = '0; m_r2 = '0; m_ed = '0; m_pc = RPC;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".valid"}, {31'b0, OutValid}, {31'b0, mv});
    chk({tag, ".ins"}, InsOut, m_ins);
    chk({tag, ".r1"}, Rdata1, m_r1);
    chk({tag, ".r2"}, Rdata2, m_r2);
    chk({tag, ".ed"}, Ed32, m_ed);
    chk({tag, ".pc"}, nextPCOut, m_pc);
  endtask

  // Called just after a rising edge with inputs already set.
  task automatic step(input string tag);
    bit acc;
    int rs;
    int rt;
    #1;
    chk({tag, ".inready"}, {31'b0, InReady},
        {31'b0, (!mv || OutReady)});
    acc = InValid && (!mv || OutReady);
    if (acc) begin
      rs = int'(Ins[25:21]);
      rt = int'(Ins[20:16]);
      m_r1 = gm[rs];
      m_r2 = gm[rt];
      if (bypass && WE && Waddr != 0) begin
        if (int'(Waddr) == rs) m_r1 = Wdata;
        if (int'(Waddr) == rt) m_r2 = Wdata;
      end
      m_ins = Ins;
      m_ed  = ref_ext(Ins);
      m_pc  = nextPC;
      mv    = 1;
    end else if (OutReady) begin
      mv = 0;
    end
    if (WE && Waddr != 0) gm[Waddr] = Wdata;
    @(posedge CLK);
    #1;
    chk_outs(tag);
  endtask

  task automatic idle();
    InValid = 0; WE = 0; OutReady = 1;
    Waddr = '0; Wdata = '0;
  endtask

  logic [5:0] ops [8];

  initial begin
`ifdef WB_BYPASS_EN
    bypass = 1;
`else
    bypass = 0;
`endif
    ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h04, 6'h23};
    RST = 0; Ins = '0; nextPC = '0;
    idle();
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst.valid", {31'b0, OutValid}, 32'd0);
    chk("rst.inready", {31'b0, InReady}, 32'd1);
    chk("rst.pc", nextPCOut, RPC);
    chk_outs("rst");
    RST = 1;
    @(posedge CLK); #1;

    for (int i = 0; i < 16; i++) begin
      Ins = (32'(2 * i) << 21) | (32'(2 * i + 1) << 16);
      nextPC = 32'(4 * i + 4); InValid = 1;
      step("rd0");
      chk("rd0.r1z", Rdata1, 32'd0);
      chk("rd0.r2z", Rdata2, 32'd0);
    end
    idle();
    step("drain0");

    WE = 1; Waddr = 5'd1; Wdata = 32'd5;
    step("wr1");
    Waddr = 5'd2; Wdata = 32'd3;
    step("wr2");
    WE = 0; Ins = 32'h00221020; nextPC = 32'd4; InValid = 1;
    step("add");
    chk("add.r1c", Rdata1, 32'd5);
    chk("add.r2c", Rdata2, 32'd3);
    chk("add.edc", Ed32, 32'h00001020);
    chk("add.vc", {31'b0, OutValid}, 32'd1);

    Ins = 32'h2000FFFE; step("addi");
    chk("addi.edc", Ed32, 32'hFFFFFFFE);
    Ins = 32'h30008003; step("andi");
    chk("andi.edc", Ed32, 32'h00008003);
    Ins = 32'h3C001234; step("lui");
    chk("lui.edc", Ed32, 32'h12340000);

    idle();
    WE = 1; Waddr = 5'd0; Wdata = 32'hDEADBEEF;
    step("wr0");
    WE = 0; Ins = 32'h00000020; InValid = 1;
    step("rd0w");
    chk("rd0w.r1c", Rdata1, 32'd0);

    idle();
    step("drain1");
    OutReady = 0; InValid = 1;
    Ins = 32'h00221022; nextPC = 32'd8;
    step("stall0");
    for (int i = 1; i < 4; i++) begin
      Ins = $urandom; nextPC = $urandom;
      WE = (i == 1); Waddr = 5'd1; Wdata = 32'h77;
      step("stall");
      chk("stall.r1c", Rdata1, 32'd5);
      chk("stall.inrdy", {31'b0, InReady}, 32'd0);
    end
    WE = 0; OutReady = 1;
    Ins = 32'h00221020; nextPC = 32'hC;
    step("unstall");
    chk("unstall.r1c", Rdata1, 32'h77);
    chk("unstall.pcc", nextPCOut, 32'hC);

    idle();
    WE = 1; Waddr = 5'd3; Wdata = 32'd7;
    step("wr3");
    Ins = 32'h00600020; InValid = 1; Wdata = 32'd9;
    step("same");
    chk("same.r1c", Rdata1, bypass ? 32'd9 : 32'd7);
    WE = 0;
    step("same2");
    chk("same2.r1c", Rdata1, 32'd9);

    for (int n = 0; n < 400; n++) begin
      Ins = {ops[$urandom_range(0, 7)], 26'($urandom)};
      nextPC = $urandom;
      InValid = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 9) < 7);
      WE = $urandom_range(0, 1) == 1;
      Waddr = 5'($urandom);
      Wdata = $urandom;
      step("rand");
    end

    idle();
    WE = 1; Waddr = 5'd4; Wdata = 32'h1234;
    OutReady = 0; InValid = 1; Ins = 32'h3C00ABCD;
    step("prerst");
    #2;
    RST = 0;
    #1;
    model_reset();
    chk("mrst.valid", {31'b0, OutValid}, 32'd0);
    chk_outs("mrst");
    #1;
    RST = 1;
    idle();
    @(posedge CLK); #1;
    Ins = 32'h00240000; InValid = 1;
    step("postrst");
    chk("postrst.r1c", Rdata1, 32'd0);
    chk("postrst.r2c", Rdata2, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
